// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the decode/execute issue controller: state encodings,
// the PC register index and the register index width.
package pipe_ctrl_pkg;

   localparam int REG_W = 4;
   localparam logic [REG_W-1:0] PC_REG = 4'd15;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STALL = 2'd1,
      ST_FLUSH = 2'd2
   } ctrl_state_e;

endpackage

// File: rtl/pipe_scoreboard.sv
// Per-register busy counters: set on a marking issue, otherwise count down to 0.
// Two source lookups plus a destination lookup, all combinational.
module pipe_scoreboard
   import pipe_ctrl_pkg::*;
#(
   parameter int NREG  = 16,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             set_en,
   input  logic [REG_W-1:0] set_reg,
   input  logic [CNT_W-1:0] set_val,
   input  logic [REG_W-1:0] rd_a,
   input  logic [REG_W-1:0] rd_b,
   input  logic [REG_W-1:0] rd_w,
   output logic             busy_a,
   output logic             busy_b,
   output logic             busy_w
);

   logic [CNT_W-1:0] busy_cnt [NREG];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int r = 0; r < NREG; r++) busy_cnt[r] <= '0;
      end else begin
         for (int r = 0; r < NREG; r++) begin
            // A new mark wins over the countdown of the same register
            if (set_en && set_reg == REG_W'(r))
               busy_cnt[r] <= set_val;
            else if (busy_cnt[r] != '0)
               busy_cnt[r] <= busy_cnt[r] - 1'b1;
         end
      end
   end

   assign busy_a = (busy_cnt[rd_a] != '0);
   assign busy_b = (busy_cnt[rd_b] != '0);
   assign busy_w = (busy_cnt[rd_w] != '0);

endmodule

// File: rtl/pipe_ctrl.sv
// Issue/hazard controller between decode and execute with redirect flush.
// Build option PIPE_CTRL_FORWARD_EN: full ALU forwarding, single load-use bubble.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int NREG       = 16,
   parameter int ALU_LAT    = 2,
   parameter int LOAD_LAT   = 3,
   parameter int BR_PENALTY = 2,
   parameter int CNT_W      = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             dec_valid,
   input  logic [REG_W-1:0] read_regA,
   input  logic [REG_W-1:0] read_regB,
   input  logic [REG_W-1:0] write_reg,
   input  logic             branch_inst,
   input  logic             data_inst,
   input  logic             load_inst,
   input  logic             write_en,
   input  logic             cond_execute,
   input  logic             mem_busy,
   output logic             issue,
   output logic             stall,
   output logic             flush,
   output logic             pc_load,
   output logic [1:0]       ctrl_state
);

   localparam int FCNT_W = (BR_PENALTY < 2) ? 1 : $clog2(BR_PENALTY + 1);

   // The counter holds the number of stall cycles a dependent instruction in
   // the very next cycle must wait, i.e. a result readable LAT cycles after
   // issue needs LAT-1 bubbles.
`ifdef PIPE_CTRL_FORWARD_EN
   localparam logic [CNT_W-1:0] ALU_SET  = '0;
   localparam logic [CNT_W-1:0] LOAD_SET = CNT_W'(1);
`else
   localparam logic [CNT_W-1:0] ALU_SET  = CNT_W'(ALU_LAT - 1);
   localparam logic [CNT_W-1:0] LOAD_SET = CNT_W'(LOAD_LAT - 1);
`endif

   ctrl_state_e       state;
   logic [FCNT_W-1:0] fcnt;
   logic              busy_a, busy_b, busy_w;
   logic              hazard, in_flush, redirect, sb_set;
   logic              unused_cls;

   // Non-load writers all take the ALU latency, so the data class flag adds nothing
   assign unused_cls = data_inst;

   pipe_scoreboard #(
      .NREG  (NREG),
      .CNT_W (CNT_W)
   ) u_scoreboard (
      .clk     (clk),
      .reset   (reset),
      .set_en  (sb_set),
      .set_reg (write_reg),
      .set_val (load_inst ? LOAD_SET : ALU_SET),
      .rd_a    (read_regA),
      .rd_b    (read_regB),
      .rd_w    (write_reg),
      .busy_a  (busy_a),
      .busy_b  (busy_b),
      .busy_w  (busy_w)
   );

   assign in_flush = (state == ST_FLUSH);
   assign hazard   = busy_a | busy_b | (write_en & busy_w);
   assign issue    = dec_valid & ~in_flush & ~hazard & ~mem_busy & ~reset;
   assign stall    = dec_valid & ~issue & ~in_flush & ~reset;
   assign sb_set   = issue & write_en & cond_execute;
   assign redirect = issue & cond_execute &
                     (branch_inst | (write_en & (write_reg == PC_REG)));

   assign pc_load    = redirect;
   assign flush      = in_flush;
   assign ctrl_state = state;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_RUN;
         fcnt  <= '0;
      end else begin
         case (state)
            ST_FLUSH: begin
               if (fcnt <= FCNT_W'(1)) begin
                  state <= ST_RUN;
                  fcnt  <= '0;
               end else begin
                  fcnt <= fcnt - 1'b1;
               end
            end
            default: begin
               if (redirect) begin
                  state <= ST_FLUSH;
                  fcnt  <= FCNT_W'(BR_PENALTY);
               end else if (dec_valid && !issue) begin
                  state <= ST_STALL;
               end else begin
                  state <= ST_RUN;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: scoreboard stalls, redirects, mem_busy, async reset.
module tb_pipe_ctrl;

   logic       clk;
   logic       reset;
   logic       dec_valid;
   logic [3:0] read_regA, read_regB, write_reg;
   logic       branch_inst, data_inst, load_inst, write_en, cond_execute, mem_busy;
   logic       issue, stall, flush, pc_load;
   logic [1:0] ctrl_state;

   int checks = 0;
   int errors = 0;

   pipe_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .dec_valid    (dec_valid),
      .read_regA    (read_regA),
      .read_regB    (read_regB),
      .write_reg    (write_reg),
      .branch_inst  (branch_inst),
      .data_inst    (data_inst),
      .load_inst    (load_inst),
      .write_en     (write_en),
      .cond_execute (cond_execute),
      .mem_busy     (mem_busy),
      .issue        (issue),
      .stall        (stall),
      .flush        (flush),
      .pc_load      (pc_load),
      .ctrl_state   (ctrl_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic chk_st(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [3:0] ra, input logic [3:0] rb,
                        input logic [3:0] wr, input logic br, input logic ld,
                        input logic we, input logic ce, input logic mb);
      dec_valid    = v;
      read_regA    = ra;
      read_regB    = rb;
      write_reg    = wr;
      branch_inst  = br;
      load_inst    = ld;
      data_inst    = we & ~ld;
      write_en     = we;
      cond_execute = ce;
      mem_busy     = mb;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      chk1("rst_issue", issue, 1'b0);
      chk1("rst_stall", stall, 1'b0);
      chk1("rst_flush", flush, 1'b0);
      chk1("rst_pc_load", pc_load, 1'b0);
      chk_st("rst_state", ctrl_state, 2'd0);
      reset = 1'b0;
      cyc();

      // ADD r1 then dependent ADD r5 <- r1: one stall cycle
      drive(1, 0, 0, 1, 0, 0, 1, 1, 0); #2;
      chk1("add_issue", issue, 1'b1);
      chk1("add_pc_load", pc_load, 1'b0);
      cyc();
      drive(1, 1, 0, 5, 0, 0, 1, 1, 0); #2;
      chk1("alu_dep_issue_c1", issue, 1'b0);
      chk1("alu_dep_stall_c1", stall, 1'b1);
      chk_st("alu_dep_state_c1", ctrl_state, 2'd0);
      cyc(); #2;
      chk1("alu_dep_issue_c2", issue, 1'b1);
      chk1("alu_dep_stall_c2", stall, 1'b0);
      chk_st("alu_dep_state_c2", ctrl_state, 2'd1);
      cyc();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0); #2;
      chk_st("alu_dep_state_c3", ctrl_state, 2'd0);
      cyc();

      // LDR r2 then dependent read of r2: two stall cycles
      drive(1, 0, 0, 2, 0, 1, 1, 1, 0); #2;
      chk1("ldr_issue", issue, 1'b1);
      cyc();
      drive(1, 2, 0, 6, 0, 0, 1, 1, 0); #2;
      chk1("ld_dep_issue_c1", issue, 1'b0);
      chk1("ld_dep_stall_c1", stall, 1'b1);
      chk_st("ld_dep_state_c1", ctrl_state, 2'd0);
      cyc(); #2;
      chk1("ld_dep_issue_c2", issue, 1'b0);
      chk1("ld_dep_stall_c2", stall, 1'b1);
      chk_st("ld_dep_state_c2", ctrl_state, 2'd1);
      cyc(); #2;
      chk1("ld_dep_issue_c3", issue, 1'b1);
      chk_st("ld_dep_state_c3", ctrl_state, 2'd1);
      cyc();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0); #2;
      chk_st("ld_dep_state_c4", ctrl_state, 2'd0);
      cyc();

      // Taken branch: pc_load pulse, two flush cycles, back to RUN
      drive(1, 0, 0, 0, 1, 0, 0, 1, 0); #2;
      chk1("br_issue", issue, 1'b1);
      chk1("br_pc_load", pc_load, 1'b1);
      chk1("br_flush_c0", flush, 1'b0);
      cyc();
      drive(1, 0, 0, 7, 0, 0, 1, 1, 0); #2;
      chk1("br_flush_c1", flush, 1'b1);
      chk1("br_issue_c1", issue, 1'b0);
      chk1("br_stall_c1", stall, 1'b0);
      chk1("br_pc_load_c1", pc_load, 1'b0);
      chk_st("br_state_c1", ctrl_state, 2'd2);
      cyc(); #2;
      chk1("br_flush_c2", flush, 1'b1);
      chk1("br_issue_c2", issue, 1'b0);
      chk_st("br_state_c2", ctrl_state, 2'd2);
      cyc(); #2;
      chk1("br_flush_c3", flush, 1'b0);
      chk_st("br_state_c3", ctrl_state, 2'd0);
      chk1("br_issue_c3", issue, 1'b1);
      cyc();

      // Condition-failed branch: issues, no redirect
      drive(1, 0, 0, 0, 1, 0, 0, 0, 0); #2;
      chk1("nbr_issue", issue, 1'b1);
      chk1("nbr_pc_load", pc_load, 1'b0);
      cyc();
      // MOV r15 with passing condition redirects like a branch
      drive(1, 0, 0, 15, 0, 0, 1, 1, 0); #2;
      chk1("nbr_flush", flush, 1'b0);
      chk1("mov15_issue", issue, 1'b1);
      chk1("mov15_pc_load", pc_load, 1'b1);
      cyc();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0); #2;
      chk1("mov15_flush_c1", flush, 1'b1);
      chk_st("mov15_state_c1", ctrl_state, 2'd2);
      cyc(); #2;
      chk1("mov15_flush_c2", flush, 1'b1);
      cyc(); #2;
      chk1("mov15_flush_c3", flush, 1'b0);
      chk_st("mov15_state_c3", ctrl_state, 2'd0);

      // mem_busy for three cycles with no hazard
      drive(1, 0, 0, 8, 0, 0, 1, 1, 1); #2;
      chk1("mb_stall_c0", stall, 1'b1);
      chk1("mb_issue_c0", issue, 1'b0);
      cyc(); #2;
      chk1("mb_stall_c1", stall, 1'b1);
      chk_st("mb_state_c1", ctrl_state, 2'd1);
      cyc(); #2;
      chk1("mb_stall_c2", stall, 1'b1);
      cyc();
      mem_busy = 1'b0; #2;
      chk1("mb_issue_c3", issue, 1'b1);
      chk1("mb_stall_c3", stall, 1'b0);
      cyc();

      // Condition-failed write to r3 leaves r3 free
      drive(1, 0, 0, 3, 0, 0, 1, 0, 0); #2;
      chk1("cf_issue", issue, 1'b1);
      cyc();
      drive(1, 3, 0, 9, 0, 0, 1, 1, 0); #2;
      chk1("cf_read_issue", issue, 1'b1);
      chk1("cf_read_stall", stall, 1'b0);
      cyc();

      // Reset during the first flush cycle while r4 is still busy
      drive(1, 0, 0, 4, 0, 1, 1, 1, 0); #2;
      chk1("rf_ldr_issue", issue, 1'b1);
      cyc();
      drive(1, 0, 0, 0, 1, 0, 0, 1, 0); #2;
      chk1("rf_br_pc_load", pc_load, 1'b1);
      cyc();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0); #2;
      chk1("rf_flush_before", flush, 1'b1);
      reset = 1'b1; #1;
      chk1("rf_flush_async", flush, 1'b0);
      chk_st("rf_state_async", ctrl_state, 2'd0);
      chk1("rf_issue_async", issue, 1'b0);
      chk1("rf_stall_async", stall, 1'b0);
      reset = 1'b0;
      drive(1, 4, 0, 10, 0, 0, 1, 1, 0); #1;
      chk1("rf_r4_issue", issue, 1'b1);
      chk1("rf_r4_stall", stall, 1'b0);
      cyc();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0); #2;
      chk1("rf_flush_after", flush, 1'b0);
      chk_st("rf_state_after", ctrl_state, 2'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
